// File: rtl/regfile_pkg.sv
// Shared constants and types for the scoreboarded register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_pkg;

    // Default geometry: 32 registers of 32 bits, matching the single-cycle core.
    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    // Architectural zero register: hardwired to 0, never written, never busy.
    localparam int REG_ZERO = 0;

    // INIT sweeps the array to zero after reset; RUN serves decode/writeback.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } rf_state_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback bundle for the register file: read taps, busy taps, alloc and write strobes.
// Latency: read data and busy are combinational; alloc/write take effect at the next clk edge.
// Backpressure: none; traffic is dropped while init_done is low.
interface regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32
);
    localparam int AW = $clog2(NREG);

    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [XLEN-1:0] read_data1;
    logic [XLEN-1:0] read_data2;
    logic            busy1;
    logic            busy2;
    logic            alloc_en;
    logic [AW-1:0]   rd_alloc;
    logic            reg_write;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] write_data;
    logic            init_done;

    // Pipeline side: decode and writeback drive indices, strobes and data.
    modport master (
        output rs1, rs2, alloc_en, rd_alloc, reg_write, rd, write_data,
        input  read_data1, read_data2, busy1, busy2, init_done
    );

    // Register file side.
    modport slave (
        input  rs1, rs2, alloc_en, rd_alloc, reg_write, rd, write_data,
        output read_data1, read_data2, busy1, busy2, init_done
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set on destination allocation, cleared on writeback, two read taps.
// Latency: set/clear visible one cycle after the strobe; taps are combinational from the stored bits.
// Backpressure: none; strobes are ignored while run is low.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREG = NREG_DEF,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic          set_vld,
    input  logic [AW-1:0] set_idx,
    input  logic          clr_vld,
    input  logic [AW-1:0] clr_idx,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    output logic          busy1,
    output logic          busy2
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Apply the release first and the allocation second, so a new producer
    // claiming the register that is retiring this cycle keeps it busy.
    always_comb begin
        busy_d = busy_q;
        if (run) begin
            if (clr_vld && (clr_idx != AW'(REG_ZERO))) begin
                busy_d[clr_idx] = 1'b0;
            end
            if (set_vld && (set_idx != AW'(REG_ZERO))) begin
                busy_d[set_idx] = 1'b1;
            end
        end
        busy_d[REG_ZERO] = 1'b0;
    end

    // Busy state register; reset drops every pending producer at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy1 = busy_q[rs1];
    assign busy2 = busy_q[rs2];

endmodule

// File: rtl/regfile_sb.sv
// 2R/1W register file with post-reset clear sweep and busy scoreboard; REGFILE_BYPASS_EN adds write-to-read forwarding.
// Latency: reads combinational; writes land at the next clk edge; clear sweep takes NREG cycles after reset.
// Backpressure: none; reg_write/alloc_en are dropped and outputs read 0 until init_done.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int XLEN = XLEN_DEF,
    parameter  int NREG = NREG_DEF,
    localparam int AW   = $clog2(NREG)
) (
    input  logic         clk,
    input  logic         rst,
    regfile_sb_if.slave  bus
);

    rf_state_t       state_q;
    rf_state_t       state_d;
    logic [AW-1:0]   clr_idx_q;
    logic [AW-1:0]   clr_idx_d;

    logic [XLEN-1:0] mem_q [NREG];
    logic            mem_we;
    logic [AW-1:0]   mem_idx;
    logic [XLEN-1:0] mem_dat;

    logic            run;
    logic            wr_hit;
    logic            sb_busy1;
    logic            sb_busy2;
    logic [XLEN-1:0] rd_dat1;
    logic [XLEN-1:0] rd_dat2;
    logic            rd_busy1;
    logic            rd_busy2;

    assign run    = (state_q == RUN);
    assign wr_hit = run && bus.reg_write && (bus.rd != AW'(REG_ZERO));

    // Clear sweep: one zero write per cycle through the whole array, then
    // hand the single write port over to writeback.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        mem_we    = 1'b0;
        mem_idx   = bus.rd;
        mem_dat   = bus.write_data;
        case (state_q)
            INIT: begin
                mem_we    = 1'b1;
                mem_idx   = clr_idx_q;
                mem_dat   = '0;
                clr_idx_d = clr_idx_q + AW'(1);
                if (clr_idx_q == AW'(NREG - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                mem_we = wr_hit;
            end
            default: begin
                state_d   = INIT;
                clr_idx_d = '0;
            end
        endcase
    end

    // FSM and sweep index; reset restarts the sweep from index 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= INIT;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Storage array; no reset, contents are defined by the clear sweep.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_idx] <= mem_dat;
        end
    end

    regfile_scoreboard #(
        .NREG (NREG)
    ) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .set_vld (bus.alloc_en),
        .set_idx (bus.rd_alloc),
        .clr_vld (bus.reg_write),
        .clr_idx (bus.rd),
        .rs1     (bus.rs1),
        .rs2     (bus.rs2),
        .busy1   (sb_busy1),
        .busy2   (sb_busy2)
    );

    // Read port 1: array/scoreboard tap, optional forwarding, then x0 and INIT forced to 0.
    always_comb begin
        rd_dat1  = mem_q[bus.rs1];
        rd_busy1 = sb_busy1;
`ifdef REGFILE_BYPASS_EN
        if (wr_hit && (bus.rs1 == bus.rd)) begin
            rd_dat1  = bus.write_data;
            rd_busy1 = 1'b0;
        end
`endif
        if (!run || (bus.rs1 == AW'(REG_ZERO))) begin
            rd_dat1  = '0;
            rd_busy1 = 1'b0;
        end
    end

    // Read port 2: same structure as port 1.
    always_comb begin
        rd_dat2  = mem_q[bus.rs2];
        rd_busy2 = sb_busy2;
`ifdef REGFILE_BYPASS_EN
        if (wr_hit && (bus.rs2 == bus.rd)) begin
            rd_dat2  = bus.write_data;
            rd_busy2 = 1'b0;
        end
`endif
        if (!run || (bus.rs2 == AW'(REG_ZERO))) begin
            rd_dat2  = '0;
            rd_busy2 = 1'b0;
        end
    end

    assign bus.read_data1 = rd_dat1;
    assign bus.read_data2 = rd_dat2;
    assign bus.busy1      = rd_busy1;
    assign bus.busy2      = rd_busy2;
    assign bus.init_done  = run;

endmodule
